// File: rtl/pico_io_responder.sv
// pico_io_responder: KCPSM6 port-bus peripheral with GPIO, a prescaled
// reload timer, an external-event counter and an acknowledged interrupt.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   port_id, out_port     processor address and write data
//   write_strobe          OUTPUT strobe (full 8-bit address match)
//   k_write_strobe        OUTPUTK strobe (port_id[3]==0, offset port_id[2:0])
//   read_strobe           INPUT strobe (qualifies read side effects)
//   in_port               registered read data, 1-cycle latency
//   interrupt             held request, cleared by interrupt_ack
//   interrupt_ack         processor acknowledge
//   gpio_in, ext_event    asynchronous inputs, synchronized internally
//   gpio_out              GPIO output register
//
// Register map (offset from BASE_ADDR):
//   0 GPIO_OUT R/W   1 GPIO_IN R   2 RELOAD R/W   3 CTRL R/W
//   4 STATUS R/W1C   5 EVCNT R (clear on read)    6-7 read 0

module pico_io_responder #(
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter logic [15:0] PRESCALE  = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic       write_strobe,
   input  logic       k_write_strobe,
   input  logic       read_strobe,
   input  logic [7:0] out_port,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic [7:0] gpio_in,
   input  logic       ext_event,
   output logic [7:0] gpio_out
);

   localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
   localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
   localparam logic [2:0] OFF_RELOAD   = 3'd2;
   localparam logic [2:0] OFF_CTRL     = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;
   localparam logic [2:0] OFF_EVCNT    = 3'd5;

   localparam logic [15:0] PRESC_LAST = PRESCALE - 16'd1;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [7:0]  reload;
   logic [2:0]  ctrl;
   logic        tmr_flag;
   logic        ext_flag;
   logic [7:0]  evcnt;
   logic [15:0] presc;
   logic [7:0]  tcount;
   logic        pend_d;

   logic [7:0]  gpio_s1;
   logic [7:0]  gpio_s2;
   logic        ev_s1;
   logic        ev_s2;
   logic        ev_s3;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [2:0] off;
   logic       blk_hit;
   logic       wr_en;
   logic       wr_gpio;
   logic       wr_reload;
   logic       wr_ctrl;
   logic       wr_status;
   logic       evcnt_clr;

   assign off     = port_id[2:0];
   assign blk_hit = (port_id[7:3] == BASE_ADDR[7:3]);

   // OUTPUTK only carries a 4-bit port, so it ignores the upper nibble
   // and the base address entirely.
   assign wr_en = (write_strobe & blk_hit)
                | (k_write_strobe & ~port_id[3]);

   assign wr_gpio   = wr_en && (off == OFF_GPIO_OUT);
   assign wr_reload = wr_en && (off == OFF_RELOAD);
   assign wr_ctrl   = wr_en && (off == OFF_CTRL);
   assign wr_status = wr_en && (off == OFF_STATUS);

   assign evcnt_clr = read_strobe && blk_hit && (off == OFF_EVCNT);

   // ------------------------------------------------------------------
   // Timer control
   // ------------------------------------------------------------------
   logic tmr_en;
   logic tmr_ie;
   logic ext_ie;
   logic tmr_start;
   logic presc_wrap;
   logic tmr_tick;
   logic tmr_expire;

   assign tmr_en = ctrl[0];
   assign tmr_ie = ctrl[1];
   assign ext_ie = ctrl[2];

   assign tmr_start  = wr_ctrl & out_port[0] & ~tmr_en;
   assign presc_wrap = (presc == PRESC_LAST);
   assign tmr_tick   = tmr_en & presc_wrap;
   assign tmr_expire = tmr_tick & (tcount == 8'd1);

   // ------------------------------------------------------------------
   // Event edge and interrupt pending
   // ------------------------------------------------------------------
   logic ev_edge;
   logic pend;
   logic pend_rise;
   logic clr_tmr;
   logic clr_ext;

   assign ev_edge   = ev_s2 & ~ev_s3;
   assign pend      = (tmr_flag & tmr_ie) | (ext_flag & ext_ie);
   assign pend_rise = pend & ~pend_d;
   assign clr_tmr   = wr_status & out_port[0];
   assign clr_ext   = wr_status & out_port[1];

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   logic [7:0] rd_data;

   always_comb begin
      rd_data = 8'h00;
      if (blk_hit) begin
         case (off)
            OFF_GPIO_OUT: rd_data = gpio_out;
            OFF_GPIO_IN:  rd_data = gpio_s2;
            OFF_RELOAD:   rd_data = reload;
            OFF_CTRL:     rd_data = {5'b0, ctrl};
            OFF_STATUS:   rd_data = {6'b0, ext_flag, tmr_flag};
            OFF_EVCNT:    rd_data = evcnt;
            default:      rd_data = 8'h00;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_s1 <= 8'h00;
         gpio_s2 <= 8'h00;
         ev_s1   <= 1'b0;
         ev_s2   <= 1'b0;
         ev_s3   <= 1'b0;
      end else begin
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;
         ev_s1   <= ext_event;
         ev_s2   <= ev_s1;
         ev_s3   <= ev_s2;
      end
   end

   // ------------------------------------------------------------------
   // Software-visible registers and read data
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_port  <= 8'h00;
         gpio_out <= 8'h00;
         reload   <= 8'h00;
         ctrl     <= 3'b000;
      end else begin
         in_port <= rd_data;
         if (wr_gpio)
            gpio_out <= out_port;
         if (wr_reload)
            reload <= out_port;
         if (wr_ctrl)
            ctrl <= out_port[2:0];
      end
   end

   // ------------------------------------------------------------------
   // Prescaler and reload down-counter
   // ------------------------------------------------------------------
   // A tick that finds the counter at 0 (RELOAD was 0) just re-reads
   // RELOAD without flagging, so a later nonzero RELOAD is picked up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= 16'h0000;
         tcount <= 8'h00;
      end else if (tmr_start) begin
         presc  <= 16'h0000;
         tcount <= reload;
      end else if (tmr_en) begin
         presc <= presc_wrap ? 16'h0000 : presc + 16'd1;
         if (presc_wrap) begin
            if (tcount <= 8'd1)
               tcount <= reload;
            else
               tcount <= tcount - 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // STATUS flags and event counter
   // ------------------------------------------------------------------
   // Hardware set beats a same-cycle W1C; a read-clear coinciding with
   // an edge leaves the new edge counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_flag <= 1'b0;
         ext_flag <= 1'b0;
         evcnt    <= 8'h00;
      end else begin
         tmr_flag <= tmr_expire | (tmr_flag & ~clr_tmr);
         ext_flag <= ev_edge | (ext_flag & ~clr_ext);
         if (evcnt_clr)
            evcnt <= ev_edge ? 8'd1 : 8'd0;
         else if (ev_edge && evcnt != 8'hFF)
            evcnt <= evcnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Interrupt request
   // ------------------------------------------------------------------
   // Only a rising pend raises the request, so a flag left set does not
   // retrigger after an acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_d    <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         pend_d <= pend;
         if (pend_rise)
            interrupt <= 1'b1;
         else if (interrupt_ack)
            interrupt <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pico_io_responder.sv
// tb_pico_io_responder: directed and randomized checks of the KCPSM6
// port responder against a register-level reference model.

module tb_pico_io_responder;

   localparam logic [15:0] PRESCALE = 16'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic       write_strobe = 1'b0;
   logic       k_write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] out_port = 8'h00;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic [7:0] gpio_in = 8'h00;
   logic       ext_event = 1'b0;
   logic [7:0] gpio_out;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_gpio   = 8'h00;
   logic [7:0] m_reload = 8'h00;
   logic [2:0] m_ctrl   = 3'b000;
   int         m_evcnt  = 0;

   pico_io_responder #(
      .BASE_ADDR (8'h00),
      .PRESCALE  (PRESCALE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .port_id        (port_id),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .out_port       (out_port),
      .in_port        (in_port),
      .interrupt      (interrupt),
      .interrupt_ack  (interrupt_ack),
      .gpio_in        (gpio_in),
      .ext_event      (ext_event),
      .gpio_out       (gpio_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id = a;
      out_port = d;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic wrk(input logic [7:0] a, input logic [7:0] d);
      port_id = a;
      out_port = d;
      k_write_strobe = 1'b1;
      tick();
      k_write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      port_id = a;
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
      d = in_port;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   task automatic pulse();
      ext_event = 1'b1;
      repeat (2) tick();
      ext_event = 1'b0;
      repeat (2) tick();
      m_evcnt = (m_evcnt >= 255) ? 255 : m_evcnt + 1;
   endtask

   task automatic wait_irq(input string tag, input int max);
      int n;
      n = 0;
      while (interrupt !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk(tag, {7'b0, interrupt}, 8'h01);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] a;
      logic [7:0] exp;
      logic [2:0] off;
      bit         match;
      bit         use_k;
      int         n;

      // ---------------- reset mid-operation ----------------
      #12;
      reset = 1'b0;
      tick();
      chk("reset_gpio_out", gpio_out, 8'h00);
      chk("reset_irq", {7'b0, interrupt}, 8'h00);
      wr(8'h00, 8'hA5);
      m_gpio = 8'hA5;
      chk("gpio_a5", gpio_out, 8'hA5);
      port_id = 8'h00;
      tick();
      chk("in_port_a5", in_port, 8'hA5);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_gpio", gpio_out, 8'h00);
      chk("async_rst_inport", in_port, 8'h00);
      chk("async_rst_irq", {7'b0, interrupt}, 8'h00);
      m_gpio = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      rd(8'h00, d);
      chk("post_rst_read", d, 8'h00);

      // ---------------- basic write/read ----------------
      wr(8'h00, 8'h3C);
      rd(8'h00, d);
      chk("rd_3c", d, 8'h3C);
      wrk(8'hF0, 8'h5A);
      chk("k_write_f0", gpio_out, 8'h5A);
      wr(8'h08, 8'h77);
      chk("nomatch_write", gpio_out, 8'h5A);
      wrk(8'h08, 8'h66);
      chk("k_bit3_ignored", gpio_out, 8'h5A);
      m_gpio = 8'h5A;
      rd(8'h06, d);
      chk("rd_off6", d, 8'h00);

      // ---------------- randomized register traffic ----------------
      for (int i = 0; i < 24; i++) begin
         off = 3'($urandom_range(0, 6));
         if (off >= 3'd4)
            off = off + 3'd1;
         match = bit'($urandom_range(0, 1));
         use_k = bit'($urandom_range(0, 1));
         d = 8'($urandom);
         if (use_k)
            a = {4'($urandom), ~match, off};
         else if (match)
            a = {5'b0, off};
         else
            a = {5'($urandom_range(1, 31)), off};
         if (use_k) wrk(a, d);
         else       wr(a, d);
         if (match) begin
            if (off == 3'd0) m_gpio = d;
            if (off == 3'd2) m_reload = d;
            if (off == 3'd3) m_ctrl = d[2:0];
         end
         chk("rand_gpio_out", gpio_out, m_gpio);

         gpio_in = 8'($urandom);
         repeat (2) tick();
         off = 3'($urandom_range(0, 5));
         if (off >= 3'd4)
            off = off + 3'd2;
         match = bit'($urandom_range(0, 1));
         a = match ? {5'b0, off} : {5'($urandom_range(1, 31)), off};
         if (!match)      exp = 8'h00;
         else if (off == 3'd0) exp = m_gpio;
         else if (off == 3'd1) exp = gpio_in;
         else if (off == 3'd2) exp = m_reload;
         else if (off == 3'd3) exp = {5'b0, m_ctrl};
         else             exp = 8'h00;
         rd(a, d);
         chk("rand_read", d, exp);
      end

      // quiesce whatever the random traffic started
      wr(8'h03, 8'h00);
      wr(8'h04, 8'h03);
      repeat (2) tick();
      ack();
      chk("quiet_irq", {7'b0, interrupt}, 8'h00);

      // ---------------- timer ----------------
      wr(8'h02, 8'h03);
      wr(8'h03, 8'h03);
      n = 0;
      while (interrupt !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      exp = 8'(int'(PRESCALE) * 3);
      chk("tmr_latency_ok",
          {7'b0, (n >= int'(exp) - 1 && n <= int'(exp) + 1)}, 8'h01);
      rd(8'h04, d);
      chk("tmr_status", d, 8'h01);
      ack();
      chk("tmr_ack", {7'b0, interrupt}, 8'h00);
      repeat (14) tick();
      chk("tmr_no_retrig", {7'b0, interrupt}, 8'h00);
      rd(8'h04, d);
      chk("tmr_status_held", d, 8'h01);
      wr(8'h03, 8'h00);
      wr(8'h04, 8'h01);
      rd(8'h04, d);
      chk("tmr_w1c", d, 8'h00);

      // RELOAD=0 never flags
      wr(8'h02, 8'h00);
      wr(8'h03, 8'h01);
      repeat (40) tick();
      rd(8'h04, d);
      chk("reload0_no_flag", d, 8'h00);
      wr(8'h03, 8'h00);

      // ---------------- event counter ----------------
      rd(8'h05, d);
      m_evcnt = 0;
      for (int i = 0; i < 300; i++)
         pulse();
      rd(8'h05, d);
      chk("evcnt_sat", d, 8'(m_evcnt));
      m_evcnt = 0;
      rd(8'h05, d);
      chk("evcnt_cleared", d, 8'h00);

      // read-clear coinciding with a synchronized edge
      ext_event = 1'b1;
      repeat (2) tick();
      rd(8'h05, d);
      chk("evcnt_coinc_old", d, 8'h00);
      ext_event = 1'b0;
      tick();
      rd(8'h05, d);
      chk("evcnt_coinc_new", d, 8'h01);

      // ---------------- W1C vs new edge ----------------
      wr(8'h04, 8'h03);
      tick();
      chk("irq_idle", {7'b0, interrupt}, 8'h00);
      wr(8'h03, 8'h04);
      pulse();
      wait_irq("ext_irq", 10);
      ack();
      ext_event = 1'b1;
      repeat (2) tick();
      wr(8'h04, 8'h02);
      ext_event = 1'b0;
      repeat (6) tick();
      chk("w1c_race_no_irq", {7'b0, interrupt}, 8'h00);
      rd(8'h04, d);
      chk("w1c_race_flag", d, 8'h02);
      wr(8'h04, 8'h02);
      rd(8'h04, d);
      chk("ext_cleared", d, 8'h00);
      pulse();
      wait_irq("ext_irq_again", 10);
      ack();

      // ---------------- interrupt priority ----------------
      wr(8'h03, 8'h00);
      wr(8'h04, 8'h03);
      pulse();
      tick();
      chk("ie_off_no_irq", {7'b0, interrupt}, 8'h00);
      wr(8'h03, 8'h04);
      tick();
      chk("ie_enable_irq", {7'b0, interrupt}, 8'h01);
      wr(8'h03, 8'h00);
      wr(8'h03, 8'h04);
      ack();
      chk("set_beats_ack", {7'b0, interrupt}, 8'h01);
      ack();
      chk("final_ack", {7'b0, interrupt}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
